// File: rtl/cic_rate_ctrl.sv
`default_nettype none
// ==== cic_rate_ctrl : CIC comb-stage rate sequencer (flush / settle / run) == Rev 1.0 ====
module cic_rate_ctrl #(
  parameter int ODW        = 16,
  parameter int FLUSH_CNT  = 2,
  parameter int SETTLE_CNT = 4,
  parameter int CW         = 16
) (
  input  logic           clk_div,
  input  logic           reset_n,
  input  logic           enable,
  input  logic           cfg_load,
  input  logic [2:0]     os_sel_req,
  input  logic [ODW-1:0] data_in,
  output logic [2:0]     os_sel,
  output logic [ODW-1:0] data_out,
  output logic           data_valid,
  output logic           busy,
  output logic           err_illegal,
  output logic [CW-1:0]  sample_cnt
);

  localparam int MAX_CNT = (FLUSH_CNT > SETTLE_CNT) ? FLUSH_CNT : SETTLE_CNT;
  localparam int TW      = $clog2(MAX_CNT + 1);
  localparam logic [TW-1:0] FLUSH_LD  = TW'(FLUSH_CNT);
  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CNT);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);

  typedef enum logic [1:0] {IDLE, FLUSH, SETTLE, RUN} state_t;

  state_t        state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [2:0]    pending_sel;
  logic [2:0]    os_sel_nx;
  logic [2:0]    eff_sel;
  logic          load_legal;
  logic          load_illegal;
  logic          run_hold;

  assign load_illegal = cfg_load && (os_sel_req == 3'b111);
  assign load_legal   = cfg_load && !load_illegal;
  assign eff_sel      = load_legal ? os_sel_req : pending_sel;
  // A sample is only qualified when RUN continues into the next cycle.
  assign run_hold     = (state == RUN) && (state_nx == RUN);

  always_comb begin
    state_nx  = state;
    timer_nx  = timer;
    os_sel_nx = os_sel;
    if (!enable) begin
      state_nx  = IDLE;
      timer_nx  = '0;
      os_sel_nx = 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (eff_sel != 3'b000) begin
            state_nx = FLUSH;
            timer_nx = FLUSH_LD;
          end
        end
        FLUSH, SETTLE: begin
          if (load_legal) begin
            // Any legal load here restarts the sequence from a clean datapath.
            state_nx  = (os_sel_req == 3'b000) ? IDLE : FLUSH;
            timer_nx  = (os_sel_req == 3'b000) ? '0 : FLUSH_LD;
            os_sel_nx = 3'b000;
          end else if (timer == TIMER_ONE) begin
            if (state == FLUSH) begin
              state_nx  = SETTLE;
              timer_nx  = SETTLE_LD;
              os_sel_nx = pending_sel;
            end else begin
              state_nx = RUN;
              timer_nx = '0;
            end
          end else begin
            timer_nx = timer - TIMER_ONE;
          end
        end
        RUN: begin
          if (load_legal && (os_sel_req == 3'b000)) begin
            state_nx  = IDLE;
            os_sel_nx = 3'b000;
          end else if (load_legal && (os_sel_req != os_sel)) begin
            state_nx  = FLUSH;
            timer_nx  = FLUSH_LD;
            os_sel_nx = 3'b000;
          end
        end
        default: begin
          state_nx  = IDLE;
          timer_nx  = '0;
          os_sel_nx = 3'b000;
        end
      endcase
    end
  end

  always_ff @(posedge clk_div) begin
    if (!reset_n) begin
      state       <= IDLE;
      timer       <= '0;
      pending_sel <= 3'b000;
      os_sel      <= 3'b000;
      data_out    <= '0;
      data_valid  <= 1'b0;
      busy        <= 1'b0;
      err_illegal <= 1'b0;
      sample_cnt  <= '0;
    end else begin
      state       <= state_nx;
      timer       <= timer_nx;
      os_sel      <= os_sel_nx;
      if (load_legal) pending_sel <= os_sel_req;
      err_illegal <= load_illegal;
      busy        <= (state_nx == FLUSH) || (state_nx == SETTLE);
      data_valid  <= run_hold;
      data_out    <= run_hold ? data_in : '0;
      if (state_nx == FLUSH) sample_cnt <= '0;
      else if (run_hold)     sample_cnt <= sample_cnt + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cic_rate_ctrl.sv
`default_nettype none
// Self-checking bench for cic_rate_ctrl: directed steps plus random traffic vs. a phase/age model.
module tb_cic_rate_ctrl;
  localparam int ODW = 16, FLUSH_CNT = 2, SETTLE_CNT = 4, CW = 16;

  logic           clk_div = 1'b0;
  logic           reset_n, enable, cfg_load;
  logic [2:0]     os_sel_req;
  logic [ODW-1:0] data_in;
  logic [2:0]     os_sel;
  logic [ODW-1:0] data_out;
  logic           data_valid, busy, err_illegal;
  logic [CW-1:0]  sample_cnt;

  cic_rate_ctrl #(.ODW(ODW), .FLUSH_CNT(FLUSH_CNT), .SETTLE_CNT(SETTLE_CNT), .CW(CW)) dut (
    .clk_div(clk_div), .reset_n(reset_n), .enable(enable), .cfg_load(cfg_load),
    .os_sel_req(os_sel_req), .data_in(data_in), .os_sel(os_sel), .data_out(data_out),
    .data_valid(data_valid), .busy(busy), .err_illegal(err_illegal), .sample_cnt(sample_cnt)
  );

  always #5 clk_div = ~clk_div;

  int checks = 0;
  int errors = 0;

  // Reference model: phase plus number of cycles spent in it.
  localparam int P_IDLE = 0, P_FLUSH = 1, P_SETTLE = 2, P_RUN = 3;
  int             ph  = P_IDLE;
  int             age = 0;
  logic [2:0]     pend = 3'b000;
  logic [2:0]     e_os = 3'b000;
  logic [ODW-1:0] e_dout = '0;
  logic           e_valid = 1'b0, e_busy = 1'b0, e_err = 1'b0;
  logic [CW-1:0]  e_cnt = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go_idle();
    ph = P_IDLE; age = 0; e_os = 3'b000; e_busy = 1'b0; e_valid = 1'b0; e_dout = '0;
  endtask

  task automatic go_flush();
    ph = P_FLUSH; age = 1; e_os = 3'b000; e_busy = 1'b1; e_valid = 1'b0; e_dout = '0; e_cnt = '0;
  endtask

  task automatic model_edge();
    logic       legal;
    logic [2:0] eff;
    legal = cfg_load && (os_sel_req != 3'b111);
    eff   = legal ? os_sel_req : pend;
    if (!reset_n) begin
      go_idle(); pend = 3'b000; e_err = 1'b0; e_cnt = '0;
      return;
    end
    e_err = cfg_load && (os_sel_req == 3'b111);
    if (!enable) go_idle();
    else if (ph == P_IDLE) begin
      if (eff != 3'b000) go_flush();
    end
    else if (legal && os_sel_req == 3'b000) go_idle();
    else if (legal && ph != P_RUN) go_flush();
    else if (legal && ph == P_RUN && os_sel_req != e_os) go_flush();
    else if (ph == P_FLUSH && age == FLUSH_CNT) begin
      ph = P_SETTLE; age = 1; e_os = pend;
    end
    else if (ph == P_SETTLE && age == SETTLE_CNT) begin
      ph = P_RUN; age = 1; e_busy = 1'b0;
    end
    else if (ph == P_RUN) begin
      e_valid = 1'b1; e_dout = data_in; e_cnt = e_cnt + 1'b1;
    end
    else age++;
    if (legal) pend = os_sel_req;
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk_div);
    #1;
    chk("os_sel", 32'(os_sel), 32'(e_os));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("data_valid", 32'(data_valid), 32'(e_valid));
    chk("data_out", 32'(data_out), 32'(e_dout));
    chk("err_illegal", 32'(err_illegal), 32'(e_err));
    chk("sample_cnt", 32'(sample_cnt), 32'(e_cnt));
    cfg_load = 1'b0;
    data_in  = ODW'($urandom);
  endtask

  task automatic load(input logic [2:0] v);
    cfg_load = 1'b1; os_sel_req = v; cyc();
  endtask

  initial begin
    int guard;
    reset_n = 1'b0; enable = 1'b0; cfg_load = 1'b0; os_sel_req = 3'b000;
    data_in = ODW'($urandom);
    repeat (2) cyc();

    // Basic bring-up at ratio 3
    reset_n = 1'b1; enable = 1'b1;
    load(3'b011);
    chk("flush_entry_busy", 32'(busy), 32'd1);
    repeat (14) cyc();
    chk("run_os_sel", 32'(os_sel), 32'd3);

    // Illegal and same-ratio loads must not disturb the stream
    load(3'b111);
    chk("illegal_pulse", 32'(err_illegal), 32'd1);
    cyc();
    load(3'b011);
    repeat (3) cyc();

    // Ratio change in RUN
    load(3'b101);
    chk("ratio_change_cnt", 32'(sample_cnt), 32'd0);
    repeat (12) cyc();

    // Load during the third SETTLE cycle restarts the flush
    load(3'b001);
    repeat (4) cyc();
    load(3'b010);
    repeat (12) cyc();
    chk("restart_os_sel", 32'(os_sel), 32'd2);

    // Drop enable with a simultaneous load, then re-enable
    enable = 1'b0;
    load(3'b100);
    repeat (3) cyc();
    enable = 1'b1;
    repeat (12) cyc();
    chk("reenable_os_sel", 32'(os_sel), 32'd4);

    // Stop via load of zero
    load(3'b000);
    repeat (3) cyc();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      enable  = ($urandom_range(0, 15) != 0);
      reset_n = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 5) == 0) begin
        cfg_load   = 1'b1;
        os_sel_req = 3'($urandom_range(0, 7));
      end
      cyc();
    end

    // Sample counter wrap
    reset_n = 1'b1; enable = 1'b1;
    load(3'b110);
    guard = 0;
    while (e_cnt != 16'hFFFF && guard < 70000) begin
      cyc();
      guard++;
    end
    chk("wrap_reach", 32'(sample_cnt), 32'hFFFF);
    cyc();
    chk("wrap_zero", 32'(sample_cnt), 32'd0);
    chk("wrap_valid", 32'(data_valid), 32'd1);

    // Reset during FLUSH
    load(3'b011);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    cyc();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_os_sel", 32'(os_sel), 32'd0);
    reset_n = 1'b1;
    repeat (4) cyc();
    chk("post_reset_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cic_rate_ctrl.md
Name: cic_rate_ctrl

Overview:
Rate/sequencing controller for the CIC comb output stage, running in the decimated clock domain. It owns the oversampling select driven into the comb datapath and performs glitch-free ratio changes: flush datapath state, apply the new ratio, discard settling samples, then release the output stream. It gates comb output into a qualified sample stream (data_out/data_valid) for downstream consumers and exposes status.

Parameters:
ODW, 16, sample width, matching the comb output width
FLUSH_CNT, 2, cycles os_sel is held at 3'b000 to clear datapath state (>=1)
SETTLE_CNT, 4, samples discarded after applying a new ratio (>=1)
CW, 16, width of sample counter

Ports:
clk_div  input  1  decimated-rate clock; all logic on rising edge
reset_n  input  1  synchronous active-low reset
enable  input  1  master run enable
cfg_load  input  1  one-cycle pulse: latch os_sel_req
os_sel_req  input  3  requested ratio; 3'b000 = stop, 3'b001..3'b110 legal, 3'b111 illegal
data_in  input  ODW  comb output sample
os_sel  output  3  registered ratio select to comb datapath
data_out  output  ODW  qualified sample
data_valid  output  1  data_out valid this cycle
busy  output  1  high in FLUSH or SETTLE
err_illegal  output  1  one-cycle pulse on illegal load
sample_cnt  output  CW  count of valid samples since last FLUSH entry

Behaviour:
- Reset (reset_n=0 at edge): state IDLE, pending_sel=0, os_sel=0, data_out=0, data_valid=0, busy=0, err_illegal=0, sample_cnt=0, counters=0. Reset mid-sequence aborts immediately; same values.
- Load handling (any state): cfg_load with os_sel_req=3'b111 -> err_illegal=1 next cycle, pending_sel unchanged, no state change. Otherwise pending_sel <= os_sel_req.
- States: IDLE, FLUSH, SETTLE, RUN. All outputs registered.
- IDLE: os_sel=0, data_valid=0, busy=0. Go to FLUSH when enable=1 and the effective pending_sel (including a same-cycle legal load) is nonzero.
- FLUSH: os_sel=0, busy=1, data_valid=0; down-counter loaded with FLUSH_CNT on entry; stays exactly FLUSH_CNT cycles, then SETTLE with os_sel<=pending_sel and counter loaded with SETTLE_CNT. sample_cnt cleared on FLUSH entry.
- SETTLE: os_sel=active ratio, busy=1, data_valid=0; stays exactly SETTLE_CNT cycles, then RUN.
- RUN: busy=0; each cycle data_out<=data_in, data_valid<=1 (one-cycle latency, first valid the cycle after first RUN cycle); sample_cnt increments per valid sample, wraps 2^CW-1 -> 0.
- Legal load with value != active ratio during RUN -> FLUSH next cycle. Load equal to active ratio -> ignored. Load during FLUSH or SETTLE -> restart FLUSH with reloaded counter, using new pending_sel.
- Load of 3'b000 in FLUSH/SETTLE/RUN -> IDLE next cycle.
- enable=0 in any state -> IDLE next cycle; os_sel=0, data_valid=0, data_out=0; pending_sel retained, so re-enable replays the full sequence. enable=0 wins over a simultaneous cfg_load, but the load still updates pending_sel or raises err_illegal.
- data_out holds its value between RUN cycles only while in RUN; cleared to 0 on any transition out of RUN.

Test Plan:
- Reset then cfg_load os_sel_req=3'b011, enable=1 -> os_sel=0 for 2 cycles, 3'b011 for 4 cycles with busy=1, then data_valid high from the following cycle; data_out equals data_in delayed 1 cycle; sample_cnt counts 1,2,3...
- In RUN at 3'b011, load 3'b101 -> next cycle os_sel=0, busy=1, data_valid=0, sample_cnt=0; after 2+4 cycles, RUN resumes with os_sel=3'b101.
- In RUN, load 3'b111 -> err_illegal one-cycle pulse, os_sel stays 3'b011, data_valid uninterrupted. Load 3'b011 (same) -> no disturbance.
- Load 3'b010 on the 3rd SETTLE cycle -> FLUSH restarts (2 cycles at 0), then full 4-cycle SETTLE at 3'b010.
- Drop enable in RUN while pulsing cfg_load 3'b100 -> IDLE next cycle, outputs 0; re-raise enable -> sequence runs with os_sel=3'b100.
- Force sample_cnt to 0xFFFF in RUN (CW=16) -> next valid sample sets it to 0x0000. Assert reset_n=0 during FLUSH -> all outputs 0 next edge, state IDLE.
